// File: rtl/mips_issue_ctrl.sv
// Issue/interlock controller beside the ID stage: register scoreboard for RAW/WAW
// interlocks, branch-resolve hold, HLT drain sequencing and a stall statistics counter.
//
// state   | meaning
// --------+------------------------------------------------------------
// RUN     | normal issue, subject to scoreboard hazards
// BR_WAIT | branch issued, holding issue until EX/MEM resolves it
// DRAIN   | HLT issued, waiting for all pending writes to retire
// HALT    | core halted; only reset leaves this state
module mips_issue_ctrl #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs,
  input  logic [AW-1:0]   id_rt,
  input  logic            id_rs_used,
  input  logic            id_rt_used,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_wr,
  input  logic            id_is_branch,
  input  logic            id_is_hlt,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic            br_resolve,
  input  logic            br_taken,
  output logic            id_issue,
  output logic            stall_if,
  output logic            bubble_ex,
  output logic            flush,
  output logic            halted,
  output logic [NREG-1:0] busy_vec,
  output logic [CW-1:0]   stall_cnt
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_BR_WAIT = 2'd1,
    S_DRAIN   = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   stall_cnt_q, stall_cnt_d;

  logic rs_hz, rt_hz, waw_hz;
  logic rs_wb_hit, rt_wb_hit, rd_wb_hit;
  logic sets_busy;

  // A write retiring in WB this cycle releases its register immediately.
  assign rs_wb_hit = wb_valid && (wb_rd == id_rs);
  assign rt_wb_hit = wb_valid && (wb_rd == id_rt);
  assign rd_wb_hit = wb_valid && (wb_rd == id_rd);

  assign rs_hz  = id_rs_used && (id_rs != '0) && busy_q[id_rs] && !rs_wb_hit;
  assign rt_hz  = id_rt_used && (id_rt != '0) && busy_q[id_rt] && !rt_wb_hit;
  assign waw_hz = id_wr      && (id_rd != '0) && busy_q[id_rd] && !rd_wb_hit;

  assign id_issue  = id_valid && (state_q == S_RUN) && !rs_hz && !rt_hz && !waw_hz;
  assign stall_if  = id_valid && !id_issue;
  assign bubble_ex = !id_issue;
  assign flush     = (state_q == S_BR_WAIT) && br_resolve && br_taken;

  assign sets_busy = id_issue && id_wr && (id_rd != '0) && !id_is_hlt;

  // Clear from WB first so a same-cycle re-issue to the same register stays pending.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) begin
      busy_d[wb_rd] = 1'b0;
    end
    if (sets_busy) begin
      busy_d[id_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN: begin
        if (id_issue && id_is_branch) begin
          state_d = S_BR_WAIT;
        end else if (id_issue && id_is_hlt) begin
          state_d = S_DRAIN;
        end
      end
      S_BR_WAIT: begin
        if (br_resolve) begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (busy_d == '0) begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_if && (state_q != S_HALT) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign halted    = (state_q == S_HALT);
  assign busy_vec  = busy_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mips_issue_ctrl.sv
// Bench for mips_issue_ctrl: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a flag/array reference model.
module tb_mips_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd, wb_rd;
  logic        id_rs_used, id_rt_used, id_wr, id_is_branch, id_is_hlt;
  logic        wb_valid, br_resolve, br_taken;
  logic        id_issue, stall_if, bubble_ex, flush, halted;
  logic [31:0] busy_vec;
  logic [15:0] stall_cnt;

  mips_issue_ctrl #(.NREG(32), .AW(5), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_rd(id_rd), .id_wr(id_wr), .id_is_branch(id_is_branch), .id_is_hlt(id_is_hlt),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .br_resolve(br_resolve), .br_taken(br_taken),
    .id_issue(id_issue), .stall_if(stall_if), .bubble_ex(bubble_ex), .flush(flush),
    .halted(halted), .busy_vec(busy_vec), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  // reference model: pending-write flags per register plus mode flags
  bit m_pend[32];
  bit m_in_branch, m_draining, m_is_halted;
  int m_cnt;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  function automatic bit pending_now(input int r);
    return (r != 0) && m_pend[r] && !(wb_valid && (int'(wb_rd) == r));
  endfunction

  always @(negedge clk) begin
    bit e_issue, e_stall, e_flush, all_clear, set_en;
    logic [31:0] e_busy;
    e_issue = id_valid && !m_in_branch && !m_draining && !m_is_halted
              && !(id_rs_used && pending_now(int'(id_rs)))
              && !(id_rt_used && pending_now(int'(id_rt)))
              && !(id_wr && pending_now(int'(id_rd)));
    e_stall = id_valid && !e_issue;
    e_flush = m_in_branch && br_resolve && br_taken;
    for (int k = 0; k < 32; k++) e_busy[k] = m_pend[k];
    if (chk_en) begin
      cmp("id_issue", {31'b0, id_issue}, {31'b0, e_issue});
      cmp("stall_if", {31'b0, stall_if}, {31'b0, e_stall});
      cmp("bubble_ex", {31'b0, bubble_ex}, {31'b0, !e_issue});
      cmp("flush", {31'b0, flush}, {31'b0, e_flush});
      cmp("busy_vec", busy_vec, e_busy);
      cmp("halted", {31'b0, halted}, {31'b0, m_is_halted});
      cmp("stall_cnt", {16'b0, stall_cnt}, m_cnt);
    end
    if (!rst_n) begin
      for (int k = 0; k < 32; k++) m_pend[k] = 0;
      m_in_branch = 0; m_draining = 0; m_is_halted = 0; m_cnt = 0;
    end else begin
      if (e_stall && !m_is_halted && m_cnt < 65535) m_cnt++;
      if (wb_valid) m_pend[wb_rd] = 0;
      set_en = e_issue && id_wr && (id_rd != 0) && !id_is_hlt;
      if (set_en) m_pend[id_rd] = 1;
      all_clear = 1;
      for (int k = 0; k < 32; k++) if (m_pend[k]) all_clear = 0;
      if (m_is_halted) begin
      end else if (m_draining) begin
        if (all_clear) begin m_draining = 0; m_is_halted = 1; end
      end else if (m_in_branch) begin
        if (br_resolve) m_in_branch = 0;
      end else if (e_issue && id_is_branch) begin
        m_in_branch = 1;
      end else if (e_issue && id_is_hlt) begin
        m_draining = 1;
      end
    end
  end

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_rs_used = 0; id_rt_used = 0;
    id_wr = 0; id_is_branch = 0; id_is_hlt = 0; wb_valid = 0; wb_rd = 0;
    br_resolve = 0; br_taken = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst_n = 0;
    idle();
    tick();
    chk_en = 1;
    tick();
    cmp("rst_busy", busy_vec, 32'h0);
    cmp("rst_cnt", {16'b0, stall_cnt}, 32'd0);
    cmp("rst_halted", {31'b0, halted}, 32'd0);
    rst_n = 1;

    // RAW stall: ADDI R1 then ADD R4,R1,R2
    id_valid = 1; id_rd = 1; id_wr = 1; id_rs_used = 1; id_rs = 0;
    settle(); cmp("addi_issue", {31'b0, id_issue}, 32'd1);
    tick();
    idle(); id_valid = 1; id_rs = 1; id_rt = 2; id_rs_used = 1; id_rt_used = 1; id_rd = 4; id_wr = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      cmp("raw_stall", {31'b0, stall_if}, 32'd1);
      cmp("raw_bubble", {31'b0, bubble_ex}, 32'd1);
      tick();
    end
    wb_valid = 1; wb_rd = 1;
    settle(); cmp("raw_release", {31'b0, id_issue}, 32'd1);
    tick();
    idle();
    settle();
    cmp("raw_busy", busy_vec, 32'h10);
    cmp("raw_cnt", {16'b0, stall_cnt}, 32'd3);
    wb_valid = 1; wb_rd = 4;
    tick();

    // write to R0 never marks busy
    idle(); id_valid = 1; id_wr = 1; id_rd = 0;
    settle(); cmp("r0_issue", {31'b0, id_issue}, 32'd1);
    tick();
    idle(); id_valid = 1; id_rs_used = 1; id_rs = 0; id_rt_used = 1; id_rt = 0;
    settle();
    cmp("r0_busy", busy_vec, 32'h0);
    cmp("r0_reader", {31'b0, id_issue}, 32'd1);
    tick();

    // branch hold, taken then not taken
    for (int rep = 0; rep < 2; rep++) begin
      idle(); id_valid = 1; id_is_branch = 1;
      settle(); cmp("br_issue", {31'b0, id_issue}, 32'd1);
      tick();
      idle(); id_valid = 1;
      for (int i = 0; i < 2; i++) begin
        settle(); cmp("br_hold", {31'b0, stall_if}, 32'd1);
        tick();
      end
      br_resolve = 1; br_taken = (rep == 0);
      settle();
      cmp("br_flush", {31'b0, flush}, (rep == 0) ? 32'd1 : 32'd0);
      cmp("br_noissue", {31'b0, id_issue}, 32'd0);
      tick();
      br_resolve = 1; br_taken = 1;
      settle();
      cmp("br_ignored", {31'b0, flush}, 32'd0);
      cmp("br_run_issue", {31'b0, id_issue}, 32'd1);
      tick();
    end

    // same-cycle clear and set of R3
    idle(); id_valid = 1; id_wr = 1; id_rd = 3;
    tick();
    wb_valid = 1; wb_rd = 3;
    settle(); cmp("r3_reissue", {31'b0, id_issue}, 32'd1);
    tick();
    idle();
    settle(); cmp("r3_setwins", {31'b0, busy_vec[3]}, 32'd1);
    wb_valid = 1; wb_rd = 3;
    tick();

    // HLT drain with R5 pending
    idle(); id_valid = 1; id_wr = 1; id_rd = 5;
    tick();
    idle(); id_valid = 1; id_is_hlt = 1;
    settle(); cmp("hlt_issue", {31'b0, id_issue}, 32'd1);
    tick();
    idle(); id_valid = 1;
    for (int i = 0; i < 2; i++) begin
      settle();
      cmp("drain_noissue", {31'b0, id_issue}, 32'd0);
      cmp("drain_halted", {31'b0, halted}, 32'd0);
      tick();
    end
    wb_valid = 1; wb_rd = 5;
    tick();
    idle();
    for (int i = 0; i < 10; i++) begin
      id_valid = 1'($urandom_range(0, 1));
      settle(); cmp("halt_sticky", {31'b0, halted}, 32'd1);
      tick();
    end

    // reset while in BR_WAIT with busy 0x6
    rst_n = 0; idle(); tick(); rst_n = 1;
    idle(); id_valid = 1; id_wr = 1; id_rd = 1; tick();
    id_rd = 2; tick();
    idle(); id_valid = 1; id_is_branch = 1; tick();
    idle(); id_valid = 1;
    settle(); cmp("pre_rst_busy", busy_vec, 32'h6);
    tick();
    rst_n = 0; tick(); rst_n = 1;
    settle();
    cmp("post_rst_busy", busy_vec, 32'h0);
    cmp("post_rst_cnt", {16'b0, stall_cnt}, 32'd0);
    cmp("post_rst_run", {31'b0, id_issue}, 32'd1);
    id_is_branch = 1;
    tick();
    idle(); id_valid = 1;
    for (int i = 0; i < 65540; i++) tick();
    settle(); cmp("sat_cnt", {16'b0, stall_cnt}, 32'hFFFF);
    tick();
    settle(); cmp("sat_hold", {16'b0, stall_cnt}, 32'hFFFF);

    // randomized traffic
    rst_n = 0; idle(); tick();
    for (int i = 0; i < 4000; i++) begin
      rst_n        = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      id_valid     = ($urandom_range(0, 3) != 0);
      id_rs        = 5'($urandom_range(0, 7));
      id_rt        = 5'($urandom_range(0, 7));
      id_rd        = 5'($urandom_range(0, 7));
      id_rs_used   = 1'($urandom_range(0, 1));
      id_rt_used   = 1'($urandom_range(0, 1));
      id_wr        = 1'($urandom_range(0, 1));
      id_is_branch = ($urandom_range(0, 9) == 0);
      id_is_hlt    = !id_is_branch && ($urandom_range(0, 59) == 0);
      wb_valid     = ($urandom_range(0, 2) == 0);
      wb_rd        = 5'($urandom_range(0, 7));
      br_resolve   = ($urandom_range(0, 4) == 0);
      br_taken     = 1'($urandom_range(0, 1));
      tick();
    end
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_issue_ctrl.md
# mips_issue_ctrl

Issue/interlock controller for the pipelined MIPS32 core. It sits beside the ID stage and decides each cycle whether the decoded instruction may enter ID/EX. It tracks in-flight destination registers in a scoreboard and stalls on RAW/WAW hazards, so programs no longer need hand-inserted dummy instructions. It also holds issue while a branch resolves and sequences HLT into a clean, drained halt.

## Interface
- NREG, 32, number of architectural registers (R0 hard-wired zero)
- AW, 5, register index width
- CW, 16, width of stall statistics counter
- clk  input  1  single pipeline clock
- rst_n  input  1  synchronous, active-low reset
- id_valid  input  1  ID holds a decoded instruction
- id_rs, id_rt  input  AW  source register indices
- id_rs_used, id_rt_used  input  1  source actually read
- id_rd  input  AW  destination index
- id_wr  input  1  instruction writes id_rd
- id_is_branch  input  1  BEQZ/BNEQZ in ID
- id_is_hlt  input  1  HLT in ID
- wb_valid  input  1  WB stage writes register file this cycle
- wb_rd  input  AW  WB destination
- br_resolve  input  1  branch outcome available from EX/MEM
- br_taken  input  1  outcome, qualified by br_resolve
- id_issue  output  1  ID instruction advances this cycle
- stall_if  output  1  hold PC and IF/ID
- bubble_ex  output  1  load NOP into ID/EX
- flush  output  1  squash IF/ID (taken branch)
- halted  output  1  core halted, sticky
- busy_vec  output  NREG  scoreboard, bit k = Rk write pending
- stall_cnt  output  CW  saturating count of stalled cycles

## Operation
- States: RUN, BR_WAIT, DRAIN, HALT. Reset → RUN.
- Source Rs is busy when it is used, nonzero, busy_vec[rs]=1, and not (wb_valid & wb_rd==rs). WB write-through bypass applies. Rt follows the same rule.
- WAW: the instruction is blocked if id_wr and id_rd≠0 and busy_vec[id_rd]=1, with the same WB bypass.
- id_issue = id_valid & state==RUN & no busy source & no WAW.
- stall_if = id_valid & ~id_issue. bubble_ex = ~id_issue.
- Scoreboard update per cycle: clear bit wb_rd if wb_valid, then set bit id_rd if id_issue & id_wr & id_rd≠0. Set wins on the same index. Bit 0 is always 0.
- RUN: issue of id_is_branch → BR_WAIT. Issue of id_is_hlt → DRAIN. An HLT does not set busy bits.
- BR_WAIT: no issue. On br_resolve, flush = br_taken for that cycle, then → RUN. br_resolve outside BR_WAIT is ignored, and flush is 0.
- DRAIN: no issue. When busy_vec after this cycle's update is all zero → HALT.
- HALT: halted=1, no issue. Exit only by reset.
- stall_cnt increments when stall_if=1 and saturates at 2^CW−1. It does not count in HALT.

## Timing
- id_issue, stall_if, bubble_ex, flush: combinational from inputs and registered state, in the same cycle.
- busy_vec, state, halted, stall_cnt: registered; they update on the clk edge following the qualifying cycle.
- Hazard release latency is 0. A stalled consumer issues in the same cycle its producer's wb_valid is asserted.
- Branch penalty is bounded by br_resolve latency. flush is a 1-cycle pulse. RUN is entered on the next edge, and issue is possible in that next cycle.
- halted rises on the edge after the cycle in which the last busy bit clears. If nothing is pending at HLT issue, it rises 2 edges after the HLT issues.
- Reset (any state, mid-branch or mid-drain): busy_vec=0, state RUN, halted=0, stall_cnt=0. Combinational outputs follow: id_issue per rules, flush=0.

## Test plan
- ADDI R1 issues (rd=1). Next cycle, ADD R4,R1,R2 has id_valid=1 → stall_if=1, bubble_ex=1 for 3 cycles. In the cycle with wb_valid=1, wb_rd=1, the ADD gives id_issue=1, busy_vec=0x10 next edge, and stall_cnt=3.
- id_wr=1, id_rd=0 issues → busy_vec stays 0. A following reader of R0 issues immediately.
- Branch issues → BR_WAIT, and id_valid is stalled 2 cycles. br_resolve=1, br_taken=1 → flush=1 for one cycle, RUN next edge. A repeat with br_taken=0 gives flush=0.
- R5 busy, HLT issues → DRAIN, later id_valid not issued. wb_valid, wb_rd=5 → halted=1 next edge and stays 1 for 10 cycles.
- Same cycle: wb_valid clears R3 while the issuing instruction writes R3 → busy_vec[3]=1 after the edge.
- rst_n=0 for one cycle while in BR_WAIT with busy_vec=0x6 → busy_vec=0, RUN, stall_cnt=0. A forced continuous stall drives stall_cnt to 0xFFFF and it holds there.
